// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_D    = 2'd2
  } grant_t;

  typedef logic [7:0] byte_lanes_t [0:LANES-1];

endpackage

// File: rtl/mem_arb_prio.sv
// rtl/mem_arb_prio.sv - data-first winner select with a fetch starvation guard
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int MAX_DSTREAK = 4
) (
  input  logic   clk,
  input  logic   rst_b,
  input  logic   if_req,
  input  logic   d_req,
  input  logic   arb,
  output grant_t grant
);

  localparam int SW = $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

  // Consecutive data grants won while fetch was waiting.
  logic [SW-1:0] streak;

  // Pick a winner only while the arbitrate strobe is high; fetch wins once the streak saturates.
  always_comb begin
    grant = GNT_NONE;
    if (arb) begin
      if (if_req && d_req) begin
        grant = (streak == STREAK_MAX) ? GNT_IF : GNT_D;
      end else if (d_req) begin
        grant = GNT_D;
      end else if (if_req) begin
        grant = GNT_IF;
      end
    end
  end

  // Streak tracks data wins against a pending fetch; any fetch win or idle fetch clears it.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      streak <= '0;
    end else if (arb) begin
      if (!if_req || grant == GNT_IF) begin
        streak <= '0;
      end else if (grant == GNT_D && streak != STREAK_MAX) begin
        streak <= streak + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a fixed-latency byte-lane memory (option: MEM_PORT_ARBITER_ALIGN_CHECK_EN)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT     = 2,
  parameter int MAX_DSTREAK = 4,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              halted,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [7:0]        d_wdata [0:3],
  output logic              d_ack,
  output logic [7:0]        d_rdata [0:3],
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data_in [0:3],
  output logic              mem_write_en,
  input  logic [7:0]        mem_data_out [0:3],
  output logic              busy
`ifdef MEM_PORT_ARBITER_ALIGN_CHECK_EN
  ,
  output logic              align_err
`endif
);

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

  arb_state_t        state, state_nxt;
  grant_t            gnt, gnt_q;
  logic              arb;
  logic [3:0]        lat_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] sel_addr;
  logic              we_q;
  byte_lanes_t       wdata_q;
  byte_lanes_t       d_rdata_q;
  logic [31:0]       if_rdata_q;
`ifdef MEM_PORT_ARBITER_ALIGN_CHECK_EN
  logic              misaligned;
  logic              misalign_q;
`endif

  mem_arb_prio #(
    .MAX_DSTREAK(MAX_DSTREAK)
  ) u_prio (
    .clk   (clk),
    .rst_b (rst_b),
    .if_req(if_req),
    .d_req (d_req),
    .arb   (arb),
    .grant (gnt)
  );

  assign sel_addr = (gnt == GNT_D) ? d_addr : if_addr;
`ifdef MEM_PORT_ARBITER_ALIGN_CHECK_EN
  assign misaligned = (sel_addr[1:0] != 2'b00);
`endif

  // State register; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and arbitrate strobe; a halted core blocks new grants only from IDLE.
  always_comb begin
    state_nxt = state;
    arb       = 1'b0;
    case (state)
      IDLE: begin
        if (!halted) begin
          arb = 1'b1;
          if (gnt != GNT_NONE) begin
`ifdef MEM_PORT_ARBITER_ALIGN_CHECK_EN
            state_nxt = misaligned ? RESP : ACCESS;
`else
            state_nxt = ACCESS;
`endif
          end
        end
      end
      ACCESS:  if (lat_cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the granted request, count memory latency and capture read lanes for loads/fetches.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      gnt_q      <= GNT_NONE;
      lat_cnt    <= 4'd0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '{default: 8'h00};
      d_rdata_q  <= '{default: 8'h00};
      if_rdata_q <= 32'h0;
`ifdef MEM_PORT_ARBITER_ALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (gnt != GNT_NONE) begin
            gnt_q   <= gnt;
            addr_q  <= sel_addr;
            we_q    <= (gnt == GNT_D) && d_we;
            lat_cnt <= LAT_INIT;
            if (gnt == GNT_D) wdata_q <= d_wdata;
`ifdef MEM_PORT_ARBITER_ALIGN_CHECK_EN
            misalign_q <= misaligned;
`endif
          end
        end
        ACCESS: begin
          if (lat_cnt == 4'd0) begin
            if (gnt_q == GNT_IF) begin
              if_rdata_q <= {mem_data_out[0], mem_data_out[1], mem_data_out[2], mem_data_out[3]};
            end else if (!we_q) begin
              d_rdata_q <= mem_data_out;
            end
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from registered state so reset clears them immediately.
  always_comb begin
    busy         = (state != IDLE);
    mem_write_en = (state == ACCESS) && we_q && (lat_cnt == LAT_INIT);
    if_ack       = (state == RESP) && (gnt_q == GNT_IF);
    d_ack        = (state == RESP) && (gnt_q == GNT_D);
    mem_addr     = addr_q;
    mem_data_in  = wdata_q;
    d_rdata      = d_rdata_q;
    if_rdata     = if_rdata_q;
`ifdef MEM_PORT_ARBITER_ALIGN_CHECK_EN
    align_err    = (state == RESP) && misalign_q;
`endif
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        halted;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [7:0]  d_wdata [0:3];
  logic        d_ack;
  logic [7:0]  d_rdata [0:3];
  logic [31:0] mem_addr;
  logic [7:0]  mem_data_in [0:3];
  logic        mem_write_en;
  logic [7:0]  mem_data_out [0:3];
  logic        busy;
`ifdef MEM_PORT_ARBITER_ALIGN_CHECK_EN
  logic        align_err;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .MEM_LAT(2),
    .MAX_DSTREAK(4),
    .ADDR_W(32)
  ) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .halted      (halted),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_ack      (if_ack),
    .if_rdata    (if_rdata),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_ack       (d_ack),
    .d_rdata     (d_rdata),
    .mem_addr    (mem_addr),
    .mem_data_in (mem_data_in),
    .mem_write_en(mem_write_en),
    .mem_data_out(mem_data_out),
    .busy        (busy)
`ifdef MEM_PORT_ARBITER_ALIGN_CHECK_EN
    ,
    .align_err   (align_err)
`endif
  );

  task automatic test_reset();
    rst_b = 1'b0; halted = 1'b0; if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0;
    d_wdata = '{8'h00, 8'h00, 8'h00, 8'h00};
    mem_data_out = '{8'h00, 8'h00, 8'h00, 8'h00};
    repeat (2) @(negedge clk);
    total++;
    if ({busy, if_ack, d_ack, mem_write_en} !== 4'b0000)
      $display("FAIL reset_ctrl: got %b expected 0000", {busy, if_ack, d_ack, mem_write_en});
    else passed++;
    total++;
    if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr: got %h expected 0", mem_addr);
    else passed++;
    total++;
    if ({d_rdata[0], d_rdata[1], d_rdata[2], d_rdata[3]} !== 32'h0 || if_rdata !== 32'h0)
      $display("FAIL reset_rdata: got d=%h if=%h expected 0", {d_rdata[0], d_rdata[1], d_rdata[2], d_rdata[3]}, if_rdata);
    else passed++;
    rst_b = 1'b1;
  endtask

  task automatic test_load();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    mem_data_out = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      total++;
      if (d_ack !== (c == 3)) $display("FAIL load_ack c%0d: got %b expected %b", c, d_ack, (c == 3));
      else passed++;
      total++;
      if (mem_write_en !== 1'b0) $display("FAIL load_we c%0d: got %b expected 0", c, mem_write_en);
      else passed++;
      if (c <= 3) begin
        total++;
        if (mem_addr !== 32'h10 || busy !== 1'b1)
          $display("FAIL load_addr c%0d: got %h busy %b expected 10 busy 1", c, mem_addr, busy);
        else passed++;
      end
      if (c == 3) begin
        total++;
        if ({d_rdata[0], d_rdata[1], d_rdata[2], d_rdata[3]} !== 32'h11223344)
          $display("FAIL load_rdata: got %h expected 11223344", {d_rdata[0], d_rdata[1], d_rdata[2], d_rdata[3]});
        else passed++;
        d_req = 1'b0;
      end
    end
    total++;
    if (busy !== 1'b0 || d_ack !== 1'b0) $display("FAIL load_idle: got busy %b ack %b expected 0 0", busy, d_ack);
    else passed++;
  endtask

  task automatic test_store();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20;
    d_wdata = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    mem_data_out = '{8'h55, 8'h66, 8'h77, 8'h88};
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      total++;
      if (mem_write_en !== (c == 1)) $display("FAIL store_we c%0d: got %b expected %b", c, mem_write_en, (c == 1));
      else passed++;
      total++;
      if (d_ack !== (c == 3)) $display("FAIL store_ack c%0d: got %b expected %b", c, d_ack, (c == 3));
      else passed++;
      if (c == 1) begin
        total++;
        if (mem_addr !== 32'h20 || {mem_data_in[0], mem_data_in[1], mem_data_in[2], mem_data_in[3]} !== 32'hDEADBEEF)
          $display("FAIL store_lanes: got %h @%h expected deadbeef @20",
                   {mem_data_in[0], mem_data_in[1], mem_data_in[2], mem_data_in[3]}, mem_addr);
        else passed++;
      end
      if (c == 3) begin
        total++;
        if ({d_rdata[0], d_rdata[1], d_rdata[2], d_rdata[3]} !== 32'h11223344)
          $display("FAIL store_rdata_kept: got %h expected 11223344", {d_rdata[0], d_rdata[1], d_rdata[2], d_rdata[3]});
        else passed++;
        d_req = 1'b0; d_we = 1'b0;
      end
    end
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h104;
    mem_data_out = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      total++;
      if (if_ack !== (c == 3) || d_ack !== 1'b0)
        $display("FAIL fetch_ack c%0d: got if %b d %b expected if %b d 0", c, if_ack, d_ack, (c == 3));
      else passed++;
      if (c == 1) begin
        total++;
        if (mem_addr !== 32'h104) $display("FAIL fetch_addr: got %h expected 104", mem_addr);
        else passed++;
      end
      if (c == 3) if_req = 1'b0;
      if (c >= 3) begin
        total++;
        if (if_rdata !== 32'hA0B1C2D3) $display("FAIL fetch_rdata c%0d: got %h expected a0b1c2d3", c, if_rdata);
        else passed++;
      end
    end
  endtask

  task automatic test_contention();
    logic [9:0] expect_if;
    int         acks;
    expect_if = 10'b1000010000;  // bit k = 1 when ack k should be a fetch
    acks = 0;
    if_req = 1'b1; if_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    for (int c = 1; c <= 60 && acks < 10; c++) begin
      @(negedge clk);
      if (if_ack || d_ack) begin
        total++;
        if (c != 3 + 4 * acks) $display("FAIL contention_spacing ack%0d: got cycle %0d expected %0d", acks, c, 3 + 4 * acks);
        else passed++;
        total++;
        if (if_ack !== expect_if[acks] || d_ack !== !expect_if[acks])
          $display("FAIL contention_order ack%0d: got if %b d %b expected if %b", acks, if_ack, d_ack, expect_if[acks]);
        else passed++;
        acks++;
      end
    end
    total++;
    if (acks != 10) $display("FAIL contention_count: got %0d expected 10", acks);
    else passed++;
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_halt();
    if_req = 1'b1; if_addr = 32'h400;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        halted = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
      end
      total++;
      if (if_ack !== (c == 3)) $display("FAIL halt_if_ack c%0d: got %b expected %b", c, if_ack, (c == 3));
      else passed++;
      if (c == 3) if_req = 1'b0;
      if (c >= 4) begin
        total++;
        if (busy !== 1'b0 || d_ack !== 1'b0) $display("FAIL halt_parked c%0d: got busy %b d_ack %b expected 0 0", c, busy, d_ack);
        else passed++;
      end
    end
    halted = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      total++;
      if (d_ack !== (c == 3)) $display("FAIL halt_resume c%0d: got %b expected %b", c, d_ack, (c == 3));
      else passed++;
      if (c == 3) d_req = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_store();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30;
    d_wdata = '{8'h01, 8'h02, 8'h03, 8'h04};
    @(negedge clk);
    total++;
    if (mem_write_en !== 1'b1) $display("FAIL rst_store_pre_we: got %b expected 1", mem_write_en);
    else passed++;
    #2 rst_b = 1'b0;
    #1;
    total++;
    if ({mem_write_en, busy, d_ack, if_ack} !== 4'b0000 || mem_addr !== 32'h0)
      $display("FAIL rst_store_async: got %b addr %h expected 0000 addr 0", {mem_write_en, busy, d_ack, if_ack}, mem_addr);
    else passed++;
    @(negedge clk);
    total++;
    if (d_ack !== 1'b0) $display("FAIL rst_store_no_ack: got %b expected 0", d_ack);
    else passed++;
    rst_b = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      total++;
      if (mem_write_en !== (c == 1) || d_ack !== (c == 3))
        $display("FAIL rst_store_regrant c%0d: got we %b ack %b expected we %b ack %b", c, mem_write_en, d_ack, (c == 1), (c == 3));
      else passed++;
      if (c == 3) begin d_req = 1'b0; d_we = 1'b0; end
    end
    @(negedge clk);
  endtask

`ifdef MEM_PORT_ARBITER_ALIGN_CHECK_EN
  task automatic test_align();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h13;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      total++;
      if (d_ack !== (c == 1) || align_err !== (c == 1) || mem_write_en !== 1'b0)
        $display("FAIL align c%0d: got ack %b err %b we %b expected %b %b 0", c, d_ack, align_err, mem_write_en, (c == 1), (c == 1));
      else passed++;
      if (c == 1) begin d_req = 1'b0; d_we = 1'b0; end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_store();
    test_fetch();
    test_contention();
    test_halt();
    test_reset_mid_store();
`ifdef MEM_PORT_ARBITER_ALIGN_CHECK_EN
    test_align();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
